// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants, state encoding and pointer helper for the UART transmit arbiter.
package uart_tx_arbiter_pkg;

  localparam int UART_DBIT           = 8;
  localparam int TIMEOUT_CYC_DEFAULT = 200000;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_START = 2'd1,
    ARB_BUSY  = 2'd2,
    ARB_HOLD  = 2'd3
  } arb_state_e;

  // Round-robin successor of idx among n requesters.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
module rr_priority_picker #(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] ptr_i,
  output logic [N_REQ-1:0]         gnt_o,
  output logic [$clog2(N_REQ)-1:0] idx_o
);

  localparam int PW = $clog2(N_REQ);

  int   pos;
  logic found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = int'(ptr_i) + k;
      if (pos >= N_REQ) pos = pos - N_REQ;
      if (!found && req_i[pos]) begin
        gnt_o[pos] = 1'b1;
        idx_o      = PW'(pos);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ byte producers: round-robin grant,
// optional multi-byte frame lock, and a watchdog that aborts a missing tx_done.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int DBIT        = UART_DBIT,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic [N_REQ-1:0]      req_valid_i,
  input  logic [N_REQ*DBIT-1:0] req_data_i,
  input  logic [N_REQ-1:0]      req_last_i,
  output logic [N_REQ-1:0]      req_ready_o,
  output logic                  tx_start_o,
  output logic [DBIT-1:0]       tx_data_o,
  input  logic                  tx_done_i,
  output logic [N_REQ-1:0]      grant_o,
  output logic                  busy_o,
  output logic                  timeout_err_o,
  input  logic                  err_clr_i
);

  localparam int PW = $clog2(N_REQ);
  localparam int WW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WW-1:0] WDOG_LIMIT = WW'(TIMEOUT_CYC - 1);

  arb_state_e        state_q, state_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [DBIT-1:0]   tx_data_q, tx_data_d;
  logic              lock_q, lock_d;
  logic [WW-1:0]     wdog_q, wdog_d;
  logic              err_q, err_d;
  logic              err_set;

  logic [N_REQ-1:0]  pick_gnt;
  logic [PW-1:0]     pick_idx;
  logic [PW-1:0]     ptr_after;
  logic [DBIT-1:0]   pick_dat;
  logic [DBIT-1:0]   own_dat;

  rr_priority_picker #(
    .N_REQ (N_REQ)
  ) u_picker (
    .req_i (req_valid_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  assign ptr_after = PW'(rr_next(int'(owner_q), N_REQ));
  assign pick_dat  = req_data_i[int'(pick_idx)*DBIT +: DBIT];
  assign own_dat   = req_data_i[int'(owner_q)*DBIT +: DBIT];

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    grant_d     = grant_q;
    tx_data_d   = tx_data_q;
    lock_d      = lock_q;
    wdog_d      = wdog_q;
    err_set     = 1'b0;
    req_ready_o = '0;

    unique case (state_q)
      ARB_IDLE: begin
        req_ready_o = pick_gnt;
        if (|req_valid_i) begin
          tx_data_d = pick_dat;
          grant_d   = pick_gnt;
          owner_d   = pick_idx;
          lock_d    = ~req_last_i[pick_idx];
          state_d   = ARB_START;
        end
      end
      ARB_START: begin
        wdog_d  = '0;
        state_d = ARB_BUSY;
      end
      ARB_BUSY: begin
        // tx_done takes priority over a watchdog expiry in the same cycle
        if (tx_done_i) begin
          if (lock_q) begin
            state_d = ARB_HOLD;
          end else begin
            rr_ptr_d = ptr_after;
            grant_d  = '0;
            state_d  = ARB_IDLE;
          end
        end else if (wdog_q == WDOG_LIMIT) begin
          err_set  = 1'b1;
          lock_d   = 1'b0;
          rr_ptr_d = ptr_after;
          grant_d  = '0;
          state_d  = ARB_IDLE;
        end else if (wdog_q != '1) begin
          wdog_d = wdog_q + WW'(1);
        end
      end
      ARB_HOLD: begin
        req_ready_o = grant_q & req_valid_i;
        if (req_valid_i[owner_q]) begin
          tx_data_d = own_dat;
          lock_d    = ~req_last_i[owner_q];
          state_d   = ARB_START;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    err_d = err_set | (err_q & ~err_clr_i);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q   <= ARB_IDLE;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      grant_q   <= '0;
      tx_data_q <= '0;
      lock_q    <= 1'b0;
      wdog_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      owner_q   <= owner_d;
      grant_q   <= grant_d;
      tx_data_q <= tx_data_d;
      lock_q    <= lock_d;
      wdog_q    <= wdog_d;
      err_q     <= err_d;
    end
  end

  assign tx_start_o    = (state_q == ARB_START);
  assign tx_data_o     = tx_data_q;
  assign grant_o       = grant_q;
  assign busy_o        = (state_q != ARB_IDLE);
  assign timeout_err_o = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table, directed corner sequences, randomized run vs. model.
module tb_uart_tx_arbiter;

  localparam int N  = 2;
  localparam int DW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid, req_last, req_ready, grant;
  logic [N*DW-1:0] req_data;
  logic          tx_start, tx_done, busy, terr, err_clr;
  logic [DW-1:0] tx_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ       (N),
    .DBIT        (DW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk_i         (clk),
    .reset_ni      (rst_n),
    .req_valid_i   (req_valid),
    .req_data_i    (req_data),
    .req_last_i    (req_last),
    .req_ready_o   (req_ready),
    .tx_start_o    (tx_start),
    .tx_data_o     (tx_data),
    .tx_done_i     (tx_done),
    .grant_o       (grant),
    .busy_o        (busy),
    .timeout_err_o (terr),
    .err_clr_i     (err_clr)
  );

  typedef struct {
    logic [1:0] v;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] last;
    logic       done;
    logic [1:0] rdy;
    logic [1:0] gnt;
    logic       bsy;
    logic       st;
    logic [7:0] dat;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                     input logic [1:0] last, input logic done, input logic [1:0] rdy,
                     input logic [1:0] gnt, input logic bsy, input logic st, input logic [7:0] dat);
    tbl.push_back('{v, d0, d1, last, done, rdy, gnt, bsy, st, dat});
  endtask

  // {ready, grant, busy, tx_start, tx_data, timeout_err}
  function automatic logic [31:0] outs();
    return {17'd0, req_ready, grant, busy, tx_start, tx_data, terr};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1ns later.
  task automatic step(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                      input logic [1:0] last, input logic done, input logic clr);
    @(negedge clk);
    req_valid = v;
    req_data  = {d1, d0};
    req_last  = last;
    tx_done   = done;
    err_clr   = clr;
    #1;
  endtask

  // Reference model state
  int         m_active, m_owner, m_age, m_more, m_ptr, m_err, m_set, win, ucnt;
  logic [1:0] er;
  logic [7:0] m_data;
  logic [31:0] ex;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not end, required end before 1ms");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_valid = '0; req_data = '0; req_last = '0; tx_done = 1'b0; err_clr = 1'b0;
    repeat (3) step(2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_state", outs(), 32'd0);

    // T1: single byte from req0
    add(2'b01, 8'hA5, 8'h00, 2'b01, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 8'h00);
    add(2'b00, 8'hA5, 8'h00, 2'b01, 1'b0, 2'b00, 2'b01, 1'b1, 1'b1, 8'hA5);
    add(2'b00, 8'hA5, 8'h00, 2'b01, 1'b1, 2'b00, 2'b01, 1'b1, 1'b0, 8'hA5);
    add(2'b00, 8'hA5, 8'h00, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 8'hA5);
    // T2: both valid, ptr now 1 -> req1 first, then alternate; tx_done in START ignored
    add(2'b11, 8'h10, 8'h20, 2'b11, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 8'hA5);
    add(2'b11, 8'h10, 8'h20, 2'b11, 1'b1, 2'b00, 2'b10, 1'b1, 1'b1, 8'h20);
    add(2'b11, 8'h10, 8'h20, 2'b11, 1'b0, 2'b00, 2'b10, 1'b1, 1'b0, 8'h20);
    add(2'b11, 8'h10, 8'h20, 2'b11, 1'b1, 2'b00, 2'b10, 1'b1, 1'b0, 8'h20);
    add(2'b11, 8'h10, 8'h20, 2'b11, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 8'h20);
    add(2'b11, 8'h10, 8'h20, 2'b11, 1'b0, 2'b00, 2'b01, 1'b1, 1'b1, 8'h10);
    add(2'b11, 8'h10, 8'h20, 2'b11, 1'b1, 2'b00, 2'b01, 1'b1, 1'b0, 8'h10);
    add(2'b11, 8'h10, 8'h20, 2'b11, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 8'h10);
    add(2'b11, 8'h10, 8'h20, 2'b11, 1'b0, 2'b00, 2'b10, 1'b1, 1'b1, 8'h20);
    add(2'b11, 8'h10, 8'h20, 2'b11, 1'b1, 2'b00, 2'b10, 1'b1, 1'b0, 8'h20);
    add(2'b11, 8'h10, 8'h20, 2'b11, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 8'h20);
    add(2'b00, 8'h10, 8'h20, 2'b11, 1'b0, 2'b00, 2'b01, 1'b1, 1'b1, 8'h10);
    add(2'b00, 8'h10, 8'h20, 2'b11, 1'b1, 2'b00, 2'b01, 1'b1, 1'b0, 8'h10);
    add(2'b00, 8'h10, 8'h20, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 8'h10);
    // T3: req1 frame 11,22,33 while req0 stays valid; tx_done in HOLD/IDLE ignored
    add(2'b11, 8'h99, 8'h11, 2'b00, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 8'h10);
    add(2'b11, 8'h99, 8'h22, 2'b00, 1'b0, 2'b00, 2'b10, 1'b1, 1'b1, 8'h11);
    add(2'b11, 8'h99, 8'h22, 2'b00, 1'b1, 2'b00, 2'b10, 1'b1, 1'b0, 8'h11);
    add(2'b01, 8'h99, 8'h22, 2'b00, 1'b1, 2'b00, 2'b10, 1'b1, 1'b0, 8'h11);
    add(2'b11, 8'h99, 8'h22, 2'b00, 1'b0, 2'b10, 2'b10, 1'b1, 1'b0, 8'h11);
    add(2'b11, 8'h99, 8'h33, 2'b10, 1'b0, 2'b00, 2'b10, 1'b1, 1'b1, 8'h22);
    add(2'b11, 8'h99, 8'h33, 2'b10, 1'b1, 2'b00, 2'b10, 1'b1, 1'b0, 8'h22);
    add(2'b11, 8'h99, 8'h33, 2'b10, 1'b0, 2'b10, 2'b10, 1'b1, 1'b0, 8'h22);
    add(2'b01, 8'h99, 8'h33, 2'b10, 1'b0, 2'b00, 2'b10, 1'b1, 1'b1, 8'h33);
    add(2'b01, 8'h99, 8'h33, 2'b10, 1'b1, 2'b00, 2'b10, 1'b1, 1'b0, 8'h33);
    add(2'b01, 8'h99, 8'h33, 2'b11, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 8'h33);
    add(2'b00, 8'h99, 8'h33, 2'b11, 1'b0, 2'b00, 2'b01, 1'b1, 1'b1, 8'h99);
    add(2'b00, 8'h99, 8'h33, 2'b11, 1'b1, 2'b00, 2'b01, 1'b1, 1'b0, 8'h99);
    add(2'b00, 8'h99, 8'h33, 2'b11, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 8'h99);
    add(2'b00, 8'h99, 8'h33, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 8'h99);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].d0, tbl[i].d1, tbl[i].last, tbl[i].done, 1'b0);
      chk($sformatf("vec%0d", i), outs(),
          {17'd0, tbl[i].rdy, tbl[i].gnt, tbl[i].bsy, tbl[i].st, tbl[i].dat, 1'b0});
    end

    // T4: watchdog abort after TO busy cycles, pending req1 then served, err_clr
    step(2'b01, 8'h5A, 8'h6B, 2'b11, 1'b0, 1'b0);
    chk("t4_accept", {30'd0, req_ready}, 32'b01);
    step(2'b10, 8'h5A, 8'h6B, 2'b11, 1'b0, 1'b0);
    chk("t4_start", {31'd0, tx_start}, 32'd1);
    for (int k = 1; k <= TO; k++) begin
      step(2'b10, 8'h5A, 8'h6B, 2'b11, 1'b0, 1'b0);
      chk($sformatf("t4_busy%0d", k), {30'd0, busy, terr}, 32'b10);
    end
    step(2'b11, 8'h5A, 8'h6B, 2'b11, 1'b0, 1'b0);
    chk("t4_abort", {28'd0, req_ready, busy, terr}, 32'b1001);
    step(2'b00, 8'h5A, 8'h6B, 2'b11, 1'b0, 1'b0);
    chk("t4_served", {21'd0, grant, tx_start, tx_data}, {21'd0, 2'b10, 1'b1, 8'h6B});
    step(2'b00, 8'h5A, 8'h6B, 2'b11, 1'b0, 1'b0);
    step(2'b00, 8'h5A, 8'h6B, 2'b11, 1'b1, 1'b0);
    step(2'b00, 8'h5A, 8'h6B, 2'b11, 1'b0, 1'b1);
    chk("t4_err_sticky", {30'd0, busy, terr}, 32'b01);
    step(2'b00, 8'h5A, 8'h6B, 2'b11, 1'b0, 1'b0);
    chk("t4_err_clr", {31'd0, terr}, 32'd0);

    // Set wins over err_clr in the abort cycle
    step(2'b01, 8'hC3, 8'h00, 2'b11, 1'b0, 1'b0);
    chk("sw_accept", {30'd0, req_ready}, 32'b01);
    for (int k = 0; k <= TO; k++) step(2'b00, 8'hC3, 8'h00, 2'b11, 1'b0, 1'b1);
    step(2'b00, 8'hC3, 8'h00, 2'b11, 1'b0, 1'b0);
    chk("set_wins", {30'd0, busy, terr}, 32'b01);

    // T5: reset during BUSY abandons the byte; late tx_done ignored
    step(2'b10, 8'h00, 8'h7E, 2'b11, 1'b0, 1'b0);
    chk("t5_accept", {30'd0, req_ready}, 32'b10);
    step(2'b00, 8'h00, 8'h7E, 2'b11, 1'b0, 1'b0);
    step(2'b00, 8'h00, 8'h7E, 2'b11, 1'b0, 1'b0);
    chk("t5_busy", {30'd0, busy, terr}, 32'b11);
    @(negedge clk);
    rst_n = 1'b0;
    step(2'b00, 8'h00, 8'h7E, 2'b11, 1'b0, 1'b0);
    rst_n = 1'b1;
    chk("t5_after_reset", {27'd0, grant, busy, tx_start, terr}, 32'd0);
    step(2'b00, 8'h00, 8'h7E, 2'b11, 1'b1, 1'b0);
    chk("t5_late_done", {30'd0, busy, tx_start}, 32'd0);
    step(2'b00, 8'h00, 8'h7E, 2'b11, 1'b0, 1'b0);
    chk("t5_no_restart", {30'd0, busy, tx_start}, 32'd0);

    // T6: tx_done on the watchdog limit cycle completes normally
    step(2'b11, 8'hE1, 8'hE2, 2'b11, 1'b0, 1'b0);
    chk("t6_accept_ptr0", {30'd0, req_ready}, 32'b01);
    step(2'b00, 8'hE1, 8'hE2, 2'b11, 1'b0, 1'b0);
    for (int k = 1; k < TO; k++) step(2'b00, 8'hE1, 8'hE2, 2'b11, 1'b0, 1'b0);
    step(2'b00, 8'hE1, 8'hE2, 2'b11, 1'b1, 1'b0);
    chk("t6_limit_busy", {30'd0, busy, terr}, 32'b10);
    step(2'b11, 8'hE1, 8'hE2, 2'b11, 1'b0, 1'b0);
    chk("t6_done_wins", {28'd0, req_ready, busy, terr}, 32'b1000);

    // Randomized run against a transaction-level model
    @(negedge clk);
    rst_n = 1'b0;
    step(2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0);
    m_active = 0; m_owner = 0; m_age = 0; m_more = 0; m_ptr = 0; m_err = 0;
    m_data = 8'h00; ucnt = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst_n     = ($urandom_range(0, 299) != 0);
      req_valid = 2'($urandom_range(0, 3));
      req_data  = 16'($urandom);
      req_last  = 2'($urandom_range(0, 3));
      err_clr   = ($urandom_range(0, 39) == 0);
      tx_done   = (ucnt == 1) || ($urandom_range(0, 99) == 0);
      #1;

      win = -1;
      for (int k = N - 1; k >= 0; k--)
        if (req_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      er = 2'b00;
      if (!m_active && win >= 0) er[win] = 1'b1;
      if (m_active && m_age < 0 && req_valid[m_owner]) er[m_owner] = 1'b1;
      ex = {17'd0, er, m_active ? 2'(1 << m_owner) : 2'b00, m_active != 0,
            (m_active != 0) && (m_age == 0), m_data, m_err != 0};
      chk($sformatf("rand%0d", c), outs(), ex);

      if (ucnt > 0) ucnt--;
      if (tx_start) ucnt = $urandom_range(1, 19);

      m_set = 0;
      if (!rst_n) begin
        m_active = 0; m_owner = 0; m_age = 0; m_more = 0; m_ptr = 0; m_err = 0;
        m_data = 8'h00; ucnt = 0;
      end else begin
        if (!m_active) begin
          if (win >= 0) begin
            m_active = 1; m_owner = win; m_age = 0;
            m_data = req_data[win*DW +: DW]; m_more = !req_last[win];
          end
        end else if (m_age == 0) begin
          m_age = 1;
        end else if (m_age > 0) begin
          if (tx_done && m_more) begin
            m_age = -1;
          end else if (tx_done || m_age == TO) begin
            m_set    = (!tx_done) ? 1 : 0;
            m_active = 0;
            m_ptr    = (m_owner + 1) % N;
          end else begin
            m_age++;
          end
        end else if (req_valid[m_owner]) begin
          m_age = 0; m_data = req_data[m_owner*DW +: DW]; m_more = !req_last[m_owner];
        end
        if (m_set != 0) m_err = 1;
        else if (err_clr) m_err = 0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
